// File: rtl/axi_rd_arb_pkg.sv
// axi_rd_arb_pkg: shared types and constants for the two-requester AXI read arbiter.
// Holds the FSM state encoding, the requester count and a small index helper.
package axi_rd_arb_pkg;

   // Number of requesters sharing the read slave.
   localparam int NUM_REQ = 2;

   // AXI burst length field width on every AR channel.
   localparam int LEN_W = 8;

   // Arbiter phases: waiting for a request, presenting AR, forwarding R beats.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   // With two requesters the "other" one is simply the inverted index.
   function automatic logic other_req(input logic idx);
      return ~idx;
   endfunction

endpackage

// File: rtl/axi_rd_arb_pick.sv
// axi_rd_arb_pick: winner selection for the read arbiter.
// AXI_RD_ARB_RR_EN defined   -> round-robin around the priority pointer.
// AXI_RD_ARB_RR_EN undefined -> fixed priority, requester 0 first; pointer ignored.
module axi_rd_arb_pick
   import axi_rd_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_ptr,
   output logic               o_grant
);

`ifdef AXI_RD_ARB_RR_EN
   // Pointed-at requester wins if it is asking, otherwise the other one.
   always_comb begin
      o_grant = i_ptr;
      if (!i_req[i_ptr]) begin
         o_grant = other_req(i_ptr);
      end
   end
`else
   // Fixed priority has no use for the pointer; tie it off visibly.
   logic w_unused_ptr;
   assign w_unused_ptr = i_ptr;

   // Requester 0 wins whenever it is valid.
   always_comb begin
      o_grant = 1'b0;
      if (!i_req[0]) begin
         o_grant = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-requester AXI read arbiter in front of one shared read slave.
// Exactly one burst is outstanding at a time: IDLE picks a winner (registered, one
// cycle), ADDR forwards its AR, DATA steers R beats back until the rlast handshake.
// R payload is broadcast; only rvalid is steered to the granted requester.
// Build option: AXI_RD_ARB_RR_EN selects round-robin, otherwise fixed priority.
module axi_rd_arbiter
   import axi_rd_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 8
)(
   input  logic                          axi_clk,
   input  logic                          axi_reset,
   // requester AR channels, slice n belongs to requester n
   input  logic [NUM_REQ*ID_WIDTH-1:0]   s_axi_arid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [NUM_REQ*LEN_W-1:0]      s_axi_arlen,
   input  logic [NUM_REQ-1:0]            s_axi_arvalid,
   output logic [NUM_REQ-1:0]            s_axi_arready,
   // requester R channels, payload broadcast
   output logic [ID_WIDTH-1:0]           s_axi_rid,
   output logic [DATA_WIDTH-1:0]         s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic                          s_axi_rlast,
   output logic [NUM_REQ-1:0]            s_axi_rvalid,
   input  logic [NUM_REQ-1:0]            s_axi_rready,
   // shared slave AR channel
   output logic [ID_WIDTH-1:0]           m_axi_arid,
   output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
   output logic [LEN_W-1:0]              m_axi_arlen,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   // shared slave R channel
   input  logic [ID_WIDTH-1:0]           m_axi_rid,
   input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rlast,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready
);

   arb_state_t r_state;
   arb_state_t w_state_nxt;
   logic       r_grant;
   logic       w_pick;
   logic       w_ptr;
   logic       w_req_any;
   logic       w_r_last_hs;

   // Per-requester views of the flat AR buses.
   logic [NUM_REQ-1:0][ID_WIDTH-1:0]   w_arid;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] w_araddr;
   logic [NUM_REQ-1:0][LEN_W-1:0]      w_arlen;

   assign w_arid    = s_axi_arid;
   assign w_araddr  = s_axi_araddr;
   assign w_arlen   = s_axi_arlen;
   assign w_req_any = |s_axi_arvalid;

   axi_rd_arb_pick u_pick (
      .i_req   (s_axi_arvalid),
      .i_ptr   (w_ptr),
      .o_grant (w_pick)
   );

`ifdef AXI_RD_ARB_RR_EN
   logic r_ptr;

   // Priority pointer swings away from the requester whose burst just completed.
   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         r_ptr <= 1'b0;
      end else if (w_r_last_hs) begin
         r_ptr <= other_req(r_grant);
      end
   end

   assign w_ptr = r_ptr;
`else
   assign w_ptr = 1'b0;
`endif

   // State register; reset abandons any burst in flight.
   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Grant is captured only when leaving IDLE and held for the whole burst.
   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         r_grant <= 1'b0;
      end else if (r_state == IDLE && w_req_any) begin
         r_grant <= w_pick;
      end
   end

   // AR payload always follows the grant; only the valid is phase-gated, so the
   // payload is stable for as long as the slave stalls arready.
   assign m_axi_arid   = w_arid[r_grant];
   assign m_axi_araddr = w_araddr[r_grant];
   assign m_axi_arlen  = w_arlen[r_grant];

   // R payload is broadcast; rvalid selects who actually takes the beat.
   assign s_axi_rid   = m_axi_rid;
   assign s_axi_rdata = m_axi_rdata;
   assign s_axi_rresp = m_axi_rresp;
   assign s_axi_rlast = m_axi_rlast;

   // Next state and handshake steering. Outside DATA m_axi_rready stays low so a
   // stray R beat is held at the slave instead of being lost.
   always_comb begin
      w_state_nxt   = r_state;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      s_axi_arready = '0;
      s_axi_rvalid  = '0;
      w_r_last_hs   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req_any) begin
               w_state_nxt = ADDR;
            end
         end
         ADDR: begin
            m_axi_arvalid          = s_axi_arvalid[r_grant];
            s_axi_arready[r_grant] = m_axi_arready;
            if (s_axi_arvalid[r_grant] && m_axi_arready) begin
               w_state_nxt = DATA;
            end
         end
         DATA: begin
            s_axi_rvalid[r_grant] = m_axi_rvalid;
            m_axi_rready          = s_axi_rready[r_grant];
            if (m_axi_rvalid && s_axi_rready[r_grant] && m_axi_rlast) begin
               w_r_last_hs = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, read data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter ID_WIDTH, default 8, AXI ID width.
REQ-004 SHALL have ports, one per line, with "[n]" meaning the bit for requester n (0 or 1):
- axi_clk  input  1  single clock for all logic.
- axi_reset  input  1  synchronous, active-high reset.
- s_axi_arid  input  2*ID_WIDTH  requester AR IDs; [n] is slice n.
- s_axi_araddr  input  2*ADDR_WIDTH  requester AR addresses; [n] is slice n.
- s_axi_arlen  input  16  requester burst lengths; [n] is slice n.
- s_axi_arvalid  input  2  requester AR valid.
- s_axi_arready  output  2  requester AR ready.
- s_axi_rid  output  ID_WIDTH  R ID, broadcast to both requesters.
- s_axi_rdata  output  DATA_WIDTH  R data, broadcast.
- s_axi_rresp  output  2  R response, broadcast.
- s_axi_rlast  output  1  R last, broadcast.
- s_axi_rvalid  output  2  per-requester R valid.
- s_axi_rready  input  2  per-requester R ready.
- m_axi_arid  output  ID_WIDTH  AR ID to the shared read slave.
- m_axi_araddr  output  ADDR_WIDTH  AR address to the slave.
- m_axi_arlen  output  8  AR burst length to the slave.
- m_axi_arvalid  output  1  AR valid to the slave.
- m_axi_arready  input  1  AR ready from the slave.
- m_axi_rid  input  ID_WIDTH  R ID from the slave.
- m_axi_rdata  input  DATA_WIDTH  R data from the slave.
- m_axi_rresp  input  2  R response from the slave.
- m_axi_rlast  input  1  R last from the slave.
- m_axi_rvalid  input  1  R valid from the slave.
- m_axi_rready  output  1  R ready to the slave.

Function
REQ-005 SHALL be an FSM with registered state: IDLE, ADDR, DATA; plus a registered grant index and a priority pointer.
REQ-006 IDLE: if any s_axi_arvalid bit is set, SHALL latch the winner into the grant register and go to ADDR next cycle; otherwise SHALL stay in IDLE. Arbitration latency is exactly 1 cycle.
REQ-007 ADDR: m_axi_ar* SHALL combinationally equal the granted requester's AR fields and valid.
REQ-008 ADDR: s_axi_arready[grant] SHALL equal m_axi_arready; the other requester's arready SHALL be 0.
REQ-009 ADDR: on m_axi_arvalid && m_axi_arready, SHALL go to DATA.
REQ-010 DATA: m_axi_r* payload SHALL be broadcast on s_axi_r*; s_axi_rvalid[grant] SHALL equal m_axi_rvalid; the other rvalid SHALL be 0; m_axi_rready SHALL equal s_axi_rready[grant].
REQ-011 DATA: on an R handshake with m_axi_rlast=1, SHALL go to IDLE, and SHALL set the priority pointer to point away from the grant (pointer <= ~grant).
REQ-012 In IDLE, m_axi_arvalid, m_axi_rready, s_axi_arready and s_axi_rvalid SHALL all be 0. An R beat arriving outside DATA SHALL be stalled, never dropped.
REQ-013 A requester SHALL NOT be granted a new burst until the current burst's rlast handshake completes: one outstanding burst total.
REQ-014 Back-to-back bursts SHALL cost 1 IDLE cycle between the rlast handshake and the next ADDR.

Reset
REQ-015 While axi_reset=1 on a clock edge, the block SHALL load state=IDLE, grant=0 and priority pointer=0; all valid/ready outputs are then 0.
REQ-016 Reset mid-burst SHALL abandon the burst: no R beat is forwarded after reset, and requesters SHALL re-issue.

Configuration
REQ-017 Macro AXI_RD_ARB_RR_EN defined: the winner SHALL be the requester at the priority pointer if it is valid, else the other requester (round-robin).
REQ-018 Macro AXI_RD_ARB_RR_EN undefined: requester 0 SHALL always win when valid (fixed priority); the pointer register SHALL be omitted.

Structure
REQ-019 Package axi_rd_arb_pkg SHALL hold the state enum (IDLE/ADDR/DATA) and the requester-count constant (2).
REQ-020 Winner selection SHALL live in sub-module axi_rd_arb_pick: inputs are the request vector and the pointer, output is the grant index.

Verification
REQ-021 arvalid=2'b01, arlen[0]=3 -> arready[0] pulses after 1 IDLE cycle; 4 beats reach rvalid[0] only; rlast on beat 4.
REQ-022 arvalid=2'b11, RR_EN defined, after reset -> grant 0 then 1, alternating; with RR_EN undefined, requester 0 wins every burst.
REQ-023 s_axi_rready[grant]=0 for 3 cycles mid-burst -> m_axi_rready=0 for those cycles and no beats are lost.
REQ-024 A new arvalid from the other requester during DATA -> its arready stays 0 until 1 cycle after the rlast handshake.
REQ-025 axi_reset asserted on beat 2 of an 8-beat burst -> next cycle state=IDLE and all valid/ready outputs are 0.
REQ-026 m_axi_arready held 0 for 5 cycles in ADDR -> m_axi_arvalid and the AR payload stay stable; the grant does not change.
